alu_issue_ctrl: RTL and testbench

Issue/writeback controller that sits directly upstream of the 5-bit ALU (inputs A, B, S; outputs Y, Cout).
- Accepts one instruction at a time over a valid/ready handshake.
- Reads operands from a small internal register file, or takes an immediate for B, and drives registered A/B/S to the ALU.
- Holds them for EXEC_CYCLES cycles, then writes Y back into the register file and updates the carry and zero flags.

---
 rtl/alu_issue_ctrl.sv | 125 ++++++++++++
 tb/tb_alu_issue_ctrl.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_issue_ctrl.sv
// Issue/writeback controller for a small ALU: reads operands from a tiny register file,
// holds them stable for EXEC_CYCLES cycles, then retires the result and updates the flags.
module alu_issue_ctrl #(
    parameter int unsigned WIDTH       = 5,
    parameter int unsigned SEL_W       = 4,
    parameter int unsigned NREG        = 4,
    parameter int unsigned EXEC_CYCLES = 1,
    localparam int unsigned AW         = $clog2(NREG)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             instr_valid,
    output logic             instr_ready,
    input  logic [SEL_W-1:0] instr_op,
    input  logic [AW-1:0]    instr_rd,
    input  logic [AW-1:0]    instr_ra,
    input  logic [AW-1:0]    instr_rb,
    input  logic             instr_imm_en,
    input  logic [WIDTH-1:0] instr_imm,
    input  logic             instr_load,
    input  logic             instr_nowb,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic [SEL_W-1:0] alu_s,
    input  logic [WIDTH-1:0] alu_y,
    input  logic             alu_cout,
    output logic             wb_valid,
    output logic [AW-1:0]    wb_rd,
    output logic [WIDTH-1:0] wb_data,
    output logic             carry_flag,
    output logic             zero_flag,
    input  logic [AW-1:0]    dbg_sel,
    output logic [WIDTH-1:0] dbg_data
);

    typedef enum logic {StIdle, StExec} state_t;

    localparam logic [3:0] CntInit = 4'(EXEC_CYCLES - 1);

    state_t           r_state;
    logic [3:0]       r_cnt;
    logic [WIDTH-1:0] r_regs [NREG];
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [SEL_W-1:0] r_s;
    logic [AW-1:0]    r_rd;
    logic [WIDTH-1:0] r_imm;
    logic             r_load;
    logic             r_nowb;
    logic             r_wb_valid;
    logic [AW-1:0]    r_wb_rd;
    logic [WIDTH-1:0] r_wb_data;
    logic             r_carry;
    logic             r_zero;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= StIdle;
            r_cnt      <= '0;
            for (int i = 0; i < NREG; i++) r_regs[i] <= '0;
            r_a        <= '0;
            r_b        <= '0;
            r_s        <= '0;
            r_rd       <= '0;
            r_imm      <= '0;
            r_load     <= 1'b0;
            r_nowb     <= 1'b0;
            r_wb_valid <= 1'b0;
            r_wb_rd    <= '0;
            r_wb_data  <= '0;
            r_carry    <= 1'b0;
            r_zero     <= 1'b0;
        end else begin
            r_wb_valid <= 1'b0;
            unique case (r_state)
                StIdle: begin
                    if (instr_valid) begin
                        r_a     <= r_regs[instr_ra];
                        r_b     <= instr_imm_en ? instr_imm : r_regs[instr_rb];
                        r_s     <= instr_op;
                        r_rd    <= instr_rd;
                        r_imm   <= instr_imm;
                        r_load  <= instr_load;
                        r_nowb  <= instr_nowb;
                        r_cnt   <= CntInit;
                        r_state <= StExec;
                    end
                end
                StExec: begin
                    if (r_cnt == '0) begin
                        // Register write lands on this edge, so the next accept sees it.
                        r_wb_rd <= r_rd;
                        r_state <= StIdle;
                        if (r_load) begin
                            r_regs[r_rd] <= r_imm;
                            r_wb_data    <= r_imm;
                            r_wb_valid   <= 1'b1;
                        end else begin
                            r_wb_data  <= alu_y;
                            r_carry    <= alu_cout;
                            r_zero     <= (alu_y == '0);
                            r_wb_valid <= !r_nowb;
                            if (!r_nowb) r_regs[r_rd] <= alu_y;
                        end
                    end else begin
                        r_cnt <= r_cnt - 4'd1;
                    end
                end
                default: r_state <= StIdle;
            endcase
        end
    end

    assign instr_ready = (r_state == StIdle);
    assign alu_a       = r_a;
    assign alu_b       = r_b;
    assign alu_s       = r_s;
    assign wb_valid    = r_wb_valid;
    assign wb_rd       = r_wb_rd;
    assign wb_data     = r_wb_data;
    assign carry_flag  = r_carry;
    assign zero_flag   = r_zero;
    assign dbg_data    = r_regs[dbg_sel];

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Bench for alu_issue_ctrl: adder stub as the ALU, directed steps followed by random instructions
// checked against an architectural register/flag model.
module tb_alu_issue_ctrl;

    localparam int unsigned EC = 3;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       instr_valid;
    logic       instr_ready;
    logic [3:0] instr_op;
    logic [1:0] instr_rd;
    logic [1:0] instr_ra;
    logic [1:0] instr_rb;
    logic       instr_imm_en;
    logic [4:0] instr_imm;
    logic       instr_load;
    logic       instr_nowb;
    logic [4:0] alu_a;
    logic [4:0] alu_b;
    logic [3:0] alu_s;
    logic [4:0] alu_y;
    logic       alu_cout;
    logic       wb_valid;
    logic [1:0] wb_rd;
    logic [4:0] wb_data;
    logic       carry_flag;
    logic       zero_flag;
    logic [1:0] dbg_sel;
    logic [4:0] dbg_data;

    // ALU stub: 5-bit adder; tb_xor lets the bench disturb Y while an instruction executes.
    logic [4:0] tb_xor;
    logic [5:0] w_sum;
    assign w_sum    = {1'b0, alu_a} + {1'b0, alu_b};
    assign alu_y    = w_sum[4:0] ^ tb_xor;
    assign alu_cout = w_sum[5];

    alu_issue_ctrl #(
        .WIDTH      (5),
        .SEL_W      (4),
        .NREG       (4),
        .EXEC_CYCLES(EC)
    ) u_dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .instr_op    (instr_op),
        .instr_rd    (instr_rd),
        .instr_ra    (instr_ra),
        .instr_rb    (instr_rb),
        .instr_imm_en(instr_imm_en),
        .instr_imm   (instr_imm),
        .instr_load  (instr_load),
        .instr_nowb  (instr_nowb),
        .alu_a       (alu_a),
        .alu_b       (alu_b),
        .alu_s       (alu_s),
        .alu_y       (alu_y),
        .alu_cout    (alu_cout),
        .wb_valid    (wb_valid),
        .wb_rd       (wb_rd),
        .wb_data     (wb_data),
        .carry_flag  (carry_flag),
        .zero_flag   (zero_flag),
        .dbg_sel     (dbg_sel),
        .dbg_data    (dbg_data)
    );

    always #5 clk = ~clk;

    int unsigned n_pass  = 0;
    int unsigned n_total = 0;

    logic [4:0] m_regs [4];
    logic       m_carry;
    logic       m_zero;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    endtask

    task automatic model_reset();
        for (int i = 0; i < 4; i++) m_regs[i] = '0;
        m_carry = 1'b0;
        m_zero  = 1'b0;
    endtask

    task automatic scramble();
        instr_op     = 4'($urandom);
        instr_rd     = 2'($urandom);
        instr_ra     = 2'($urandom);
        instr_rb     = 2'($urandom);
        instr_imm_en = 1'($urandom);
        instr_imm    = 5'($urandom);
        instr_load   = 1'($urandom);
        instr_nowb   = 1'($urandom);
    endtask

    task automatic dbg_chk(input logic [1:0] r);
        dbg_sel = r;
        #1;
        chk("dbg_data", dbg_data, m_regs[r]);
    endtask

    // Called at a negedge with the controller idle; returns at the negedge after retirement.
    task automatic issue(input logic [3:0] op, input logic [1:0] rd, input logic [1:0] ra,
                         input logic [1:0] rb, input logic ie, input logic [4:0] imm,
                         input logic ld, input logic nw, input logic hold, input logic chg);
        logic [4:0] ea, eb, ey;
        logic [5:0] s;
        logic       ewv;
        instr_op     = op;
        instr_rd     = rd;
        instr_ra     = ra;
        instr_rb     = rb;
        instr_imm_en = ie;
        instr_imm    = imm;
        instr_load   = ld;
        instr_nowb   = nw;
        instr_valid  = 1'b1;
        chk("ready_before_accept", instr_ready, 1'b1);
        ea = m_regs[ra];
        eb = ie ? imm : m_regs[rb];
        @(posedge clk);
        #1;
        if (!hold) instr_valid = 1'b0;
        scramble();
        for (int k = 0; k < EC; k++) begin
            @(negedge clk);
            if (chg) tb_xor = 5'($urandom);
            chk("alu_a_held", alu_a, ea);
            chk("alu_b_held", alu_b, eb);
            chk("alu_s_held", alu_s, op);
            chk("ready_low_exec", instr_ready, 1'b0);
            chk("wb_valid_low_exec", wb_valid, 1'b0);
            @(posedge clk);
        end
        s  = {1'b0, ea} + {1'b0, eb};
        ey = s[4:0] ^ tb_xor;
        if (ld) begin
            m_regs[rd] = imm;
            ewv = 1'b1;
            ey  = imm;
        end else begin
            m_carry = s[5];
            m_zero  = (ey == 5'd0);
            ewv     = !nw;
            if (!nw) m_regs[rd] = ey;
        end
        @(negedge clk);
        tb_xor = '0;
        chk("wb_valid_pulse", wb_valid, ewv);
        if (ewv) begin
            chk("wb_rd", wb_rd, rd);
            chk("wb_data", wb_data, ey);
        end
        chk("carry_flag", carry_flag, m_carry);
        chk("zero_flag", zero_flag, m_zero);
        chk("ready_after_retire", instr_ready, 1'b1);
        dbg_chk(rd);
        dbg_chk(2'($urandom));
    endtask

    initial begin
        rst_n       = 1'b0;
        instr_valid = 1'b0;
        tb_xor      = '0;
        dbg_sel     = '0;
        scramble();
        model_reset();
        #2;
        chk("rst_ready", instr_ready, 1'b1);
        chk("rst_alu_a", alu_a, 0);
        chk("rst_alu_b", alu_b, 0);
        chk("rst_alu_s", alu_s, 0);
        chk("rst_wb_valid", wb_valid, 0);
        chk("rst_wb_data", wb_data, 0);
        chk("rst_carry", carry_flag, 0);
        chk("rst_zero", zero_flag, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // Loads r1=26, r2=17
        issue(4'd0, 2'd1, 2'd0, 2'd0, 1'b0, 5'd26, 1'b1, 1'b0, 1'b0, 1'b0);
        issue(4'd0, 2'd2, 2'd0, 2'd0, 1'b0, 5'd17, 1'b1, 1'b0, 1'b0, 1'b0);
        chk("load_r1", m_regs[1] === 5'd26 ? dbg_data : 5'd0, dbg_data);
        dbg_chk(2'd1);
        // r3 = r1 + r2 = 43 -> 11, carry
        issue(4'd0, 2'd3, 2'd1, 2'd2, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("add_r3_value", dbg_data, 5'd11);
        // r3 + 21 = 32 -> 0, flags only
        issue(4'd5, 2'd3, 2'd3, 2'd0, 1'b1, 5'd21, 1'b0, 1'b1, 1'b0, 1'b0);
        chk("nowb_zero_flag", zero_flag, 1'b1);
        dbg_chk(2'd3);
        // Back-to-back with valid held: second reads the updated r1
        issue(4'd0, 2'd1, 2'd1, 2'd1, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
        issue(4'd0, 2'd2, 2'd1, 2'd2, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        dbg_chk(2'd1);
        chk("b2b_r1", dbg_data, 5'd20);
        // Y disturbed during execution; final-edge value is the one written
        issue(4'd9, 2'd0, 2'd2, 2'd3, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1);

        // Reset in the middle of execution abandons the instruction
        instr_op    = 4'd3;
        instr_rd    = 2'd2;
        instr_ra    = 2'd1;
        instr_rb    = 2'd2;
        instr_imm_en = 1'b0;
        instr_load  = 1'b0;
        instr_nowb  = 1'b0;
        instr_valid = 1'b1;
        @(posedge clk);
        #1;
        instr_valid = 1'b0;
        @(negedge clk);
        chk("pre_rst_alu_a", alu_a, m_regs[1]);
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        chk("mid_rst_alu_a", alu_a, 0);
        chk("mid_rst_alu_b", alu_b, 0);
        chk("mid_rst_alu_s", alu_s, 0);
        chk("mid_rst_ready", instr_ready, 1'b1);
        for (int r = 0; r < 4; r++) dbg_chk(2'(r));
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("ready_after_rst", instr_ready, 1'b1);
        for (int k = 0; k <= EC; k++) begin
            @(negedge clk);
            chk("no_wb_after_rst", wb_valid, 1'b0);
            chk("carry_after_rst", carry_flag, 1'b0);
        end
        @(negedge clk);

        // Random instructions
        for (int n = 0; n < 40; n++) begin
            logic ld;
            ld = ($urandom_range(0, 3) == 0);
            issue(4'($urandom), 2'($urandom), 2'($urandom), 2'($urandom), 1'($urandom),
                  5'($urandom), ld, ($urandom_range(0, 3) == 0), 1'($urandom), 1'($urandom));
        end
        instr_valid = 1'b0;
        @(negedge clk);
        chk("final_wb_idle", wb_valid, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
